// File: rtl/scan_decoder.sv
// Rebuilds the four digits of a time-multiplexed display scan from its digit/select bus.
// Samples are synchronized and debounced, then checked for 0-1-2-3 scan order and lock.
module scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dig_4,
    input  logic [3:0] bus_4,
    output logic [3:0] time0,
    output logic [3:0] time1,
    output logic [3:0] time2,
    output logic [3:0] time3,
    output logic       frame_done,
    output logic       scan_ok,
    output logic       err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]    SAMPLE_RST = 8'h0F;
    localparam logic [7:0]    STAB_MAX   = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0]    STAB_ACC   = 8'(STABLE_CYCLES - 2);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNCING = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    logic [7:0]    sync1_q, sync1_d;
    logic [7:0]    sync2_q, sync2_d;
    logic [7:0]    held_q, held_d;
    logic [7:0]    stab_cnt_q, stab_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    state_t        state_q, state_d;
    logic [1:0]    expected_q, expected_d;
    logic          frame_done_q, frame_done_d;
    logic          err_q, err_d;
    logic          scan_ok_q, scan_ok_d;

    logic          accept;
    logic          sel_legal;
    logic          legal;
    logic          illegal;
    logic          timeout;
    logic [1:0]    acc_idx;
    logic [3:0]    acc_sel;
    logic [3:0]    acc_dig;
    logic          synced;
    logic          in_order;

    // Two-flop synchronizer on the combined {dig, sel} bus
    always_comb begin
        sync1_d = {dig_4, bus_4};
        sync2_d = sync1_q;
    end

    // Accept fires on the cycle the run of equal samples reaches STABLE_CYCLES;
    // the counter then parks so a long stable value is taken only once.
    always_comb begin
        held_d     = held_q;
        stab_cnt_d = stab_cnt_q;
        accept     = 1'b0;
        if (sync2_q != held_q) begin
            held_d     = sync2_q;
            stab_cnt_d = '0;
        end else if (stab_cnt_q != STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + 8'd1;
            accept     = (stab_cnt_q == STAB_ACC);
        end
    end

    assign acc_sel = held_q[3:0];
    assign acc_dig = held_q[7:4];

    always_comb begin
        acc_idx   = 2'd0;
        sel_legal = 1'b1;
        case (acc_sel)
            4'b0111: acc_idx = 2'd0;
            4'b1011: acc_idx = 2'd1;
            4'b1101: acc_idx = 2'd2;
            4'b1110: acc_idx = 2'd3;
            default: sel_legal = 1'b0;
        endcase
    end

    assign legal   = accept & sel_legal;
    assign illegal = accept & ~sel_legal & (acc_sel != 4'b1111);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        timeout   = 1'b0;
        if (legal) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
            timeout   = (tmo_cnt_d == TMO_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= SAMPLE_RST;
            sync2_q    <= SAMPLE_RST;
            held_q     <= SAMPLE_RST;
            stab_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            held_q     <= held_d;
            stab_cnt_q <= stab_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    // Digit registers load on any legal accept, whatever the lock state
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        logic [3:0] digit_q, digit_d;

        always_comb begin
            digit_d = digit_q;
            if (legal && (acc_idx == 2'(gi))) begin
                digit_d = acc_dig;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                digit_q <= '0;
            end else begin
                digit_q <= digit_d;
            end
        end
    end

    assign time0 = g_digit[0].digit_q;
    assign time1 = g_digit[1].digit_q;
    assign time2 = g_digit[2].digit_q;
    assign time3 = g_digit[3].digit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            expected_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
        end
    end

    assign synced   = (state_q != ST_IDLE);
    assign in_order = legal && (acc_idx == expected_q);

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        case (state_q)
            ST_IDLE: begin
                if (legal && (acc_idx == 2'd0)) begin
                    state_d    = ST_SYNCING;
                    expected_d = 2'd1;
                end
            end
            ST_SYNCING, ST_LOCKED: begin
                if (legal) begin
                    if (in_order) begin
                        expected_d = expected_q + 2'd1;
                        if (acc_idx == 2'd3) begin
                            state_d = ST_LOCKED;
                        end
                    end else if (acc_idx == 2'd0) begin
                        state_d    = ST_SYNCING;
                        expected_d = 2'd1;
                    end else begin
                        state_d    = ST_IDLE;
                        expected_d = 2'd0;
                    end
                end else if (timeout) begin
                    state_d    = ST_IDLE;
                    expected_d = 2'd0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                expected_d = 2'd0;
            end
        endcase
    end

    // All error sources merge into one pulse
    always_comb begin
        frame_done_d = synced && in_order && (acc_idx == 2'd3);
        err_d        = illegal
                     | (synced && legal && !in_order)
                     | (synced && timeout);
        scan_ok_d    = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            scan_ok_q    <= 1'b0;
        end else begin
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            scan_ok_q    <= scan_ok_d;
        end
    end

    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign scan_ok    = scan_ok_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: drives scan slots and compares per-slot output summaries
// against a slot/edge-level model of the scan protocol.
module tb_scan_decoder;

    localparam int STABLE   = 4;
    localparam int TIMEOUT  = 1024;
    localparam int ACC_EDGE = STABLE + 2;
    localparam logic [7:0] BLANK = 8'h0F;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] dig_4 = 4'h0;
    logic [3:0] bus_4 = 4'hF;
    logic [3:0] time0, time1, time2, time3;
    logic       frame_done, scan_ok, err;

    scan_decoder #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dig_4     (dig_4),
        .bus_4     (bus_4),
        .time0     (time0),
        .time1     (time1),
        .time2     (time2),
        .time3     (time3),
        .frame_done(frame_done),
        .scan_ok   (scan_ok),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  fd_cnt;
        logic [7:0]  err_cnt;
        logic [15:0] fd_edge;
        logic [15:0] err_edge;
        logic [15:0] ok_edge;
        logic        ok;
        logic [15:0] times;
    } slot_sum_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          edge_ctr = 0;
    // Model: m_run counts in-order digits since the last sync (-1 = not synced)
    int          m_run;
    int          m_last_legal;
    logic [3:0]  m_time [4];
    logic [7:0]  m_prev_val;
    slot_sum_t   obs_sum, exp_sum;

    function automatic int sel_to_idx(input logic [3:0] sel);
        case (sel)
            4'b0111: return 0;
            4'b1011: return 1;
            4'b1101: return 2;
            4'b1110: return 3;
            4'b1111: return -1;
            default: return -2;
        endcase
    endfunction

    function automatic logic [3:0] idx_to_sel(input int idx);
        logic [3:0] one_hot;
        one_hot = 4'b1000 >> idx;
        return ~one_hot;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_time[i] = 4'h0;
        m_run        = -1;
        m_prev_val   = BLANK;
        m_last_legal = edge_ctr;
    endtask

    task automatic model_edge(input bit acc, input logic [7:0] v, output bit fd, output bit er);
        int idx;
        bit legal_acc;
        fd = 1'b0;
        er = 1'b0;
        legal_acc = 1'b0;
        if (acc) begin
            idx = sel_to_idx(v[3:0]);
            if (idx >= 0) begin
                legal_acc    = 1'b1;
                m_time[idx]  = v[7:4];
                m_last_legal = edge_ctr;
                if (m_run < 1) begin
                    if (idx == 0) m_run = 1;
                end else if (idx == m_run % 4) begin
                    m_run = m_run + 1;
                    fd = (idx == 3);
                end else begin
                    er = 1'b1;
                    m_run = (idx == 0) ? 1 : -1;
                end
            end else if (idx == -2) begin
                er = 1'b1;
            end
        end
        if (!legal_acc && m_run >= 1 && (edge_ctr - m_last_legal) == TIMEOUT) begin
            er = 1'b1;
            m_run = -1;
        end
    endtask

    // Present one value for len cycles; called while between clock edges.
    task automatic run_slot(input logic [3:0] sel, input logic [3:0] dig, input int len);
        logic [7:0] v;
        bit acc_slot, fd, er, ok_prev_e;
        logic ok_prev_o;
        v = {dig, sel};
        acc_slot = (v != m_prev_val) && (len >= ACC_EDGE);
        m_prev_val = v;
        dig_4 = dig;
        bus_4 = sel;
        obs_sum = '0;
        exp_sum = '0;
        ok_prev_o = scan_ok;
        ok_prev_e = (m_run >= 4);
        for (int e = 1; e <= len; e++) begin
            @(posedge clk);
            #1;
            edge_ctr++;
            model_edge(acc_slot && (e == ACC_EDGE), v, fd, er);
            if (fd) begin
                exp_sum.fd_cnt  = exp_sum.fd_cnt + 8'd1;
                exp_sum.fd_edge = 16'(e);
            end
            if (er) begin
                exp_sum.err_cnt  = exp_sum.err_cnt + 8'd1;
                exp_sum.err_edge = 16'(e);
            end
            if ((m_run >= 4) != ok_prev_e) begin
                exp_sum.ok_edge = 16'(e);
                ok_prev_e = (m_run >= 4);
            end
            if (frame_done === 1'b1) begin
                obs_sum.fd_cnt  = obs_sum.fd_cnt + 8'd1;
                obs_sum.fd_edge = 16'(e);
            end
            if (err === 1'b1) begin
                obs_sum.err_cnt  = obs_sum.err_cnt + 8'd1;
                obs_sum.err_edge = 16'(e);
            end
            if (scan_ok !== ok_prev_o) begin
                obs_sum.ok_edge = 16'(e);
                ok_prev_o = scan_ok;
            end
        end
        exp_sum.ok    = (m_run >= 4);
        exp_sum.times = {m_time[3], m_time[2], m_time[1], m_time[0]};
        obs_sum.ok    = scan_ok;
        obs_sum.times = {time3, time2, time1, time0};
    endtask

    task automatic test_reset();
        edge_ctr = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({time3, time2, time1, time0, frame_done, scan_ok, err} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {time3, time2, time1, time0, frame_done, scan_ok, err});
        end
        rst_n = 1'b1;
        m_last_legal = edge_ctr;
        run_slot(4'hF, 4'h0, 20);
        $display("reset idle slot: obs %h", obs_sum);
        n_checks++;
        if (obs_sum !== exp_sum) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected %h", obs_sum, exp_sum);
        end
    endtask

    task automatic test_scan_frames();
        int fd_total = 0;
        int err_total = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 4; i++) begin
                run_slot(idx_to_sel(i), 4'(i + 1), 10);
                $display("scan f%0d idx%0d: obs %h", f, i, obs_sum);
                fd_total  += int'(obs_sum.fd_cnt);
                err_total += int'(obs_sum.err_cnt);
                n_checks++;
                if (obs_sum !== exp_sum) begin
                    n_fail++;
                    $display("FAIL scan_frames f%0d idx%0d: got %h expected %h", f, i, obs_sum, exp_sum);
                end
                if (i == 3) begin
                    n_checks++;
                    if (obs_sum.fd_edge !== 16'(STABLE + 2)) begin
                        n_fail++;
                        $display("FAIL frame_done_latency f%0d: got edge %0d expected %0d", f, obs_sum.fd_edge, STABLE + 2);
                    end
                end
            end
        end
        n_checks++;
        if (fd_total != 3 || err_total != 0) begin
            n_fail++;
            $display("FAIL scan_pulse_totals: got fd=%0d err=%0d expected fd=3 err=0", fd_total, err_total);
        end
        n_checks++;
        if (obs_sum.times !== 16'h4321 || obs_sum.ok !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_final: got times=%h ok=%b expected times=4321 ok=1", obs_sum.times, obs_sum.ok);
        end
    endtask

    task automatic test_glitch();
        int err_total = 0;
        run_slot(4'b1011, 4'hF, 2);
        err_total += int'(obs_sum.err_cnt);
        n_checks++;
        if (obs_sum !== exp_sum) begin
            n_fail++;
            $display("FAIL glitch_slot: got %h expected %h", obs_sum, exp_sum);
        end
        run_slot(idx_to_sel(0), 4'h1, 8);
        err_total += int'(obs_sum.err_cnt);
        n_checks++;
        if (obs_sum !== exp_sum) begin
            n_fail++;
            $display("FAIL glitch_idx0: got %h expected %h", obs_sum, exp_sum);
        end
        for (int i = 1; i < 4; i++) begin
            run_slot(idx_to_sel(i), 4'(i + 1), 10);
            $display("glitch frame idx%0d: obs %h", i, obs_sum);
            err_total += int'(obs_sum.err_cnt);
            n_checks++;
            if (obs_sum !== exp_sum) begin
                n_fail++;
                $display("FAIL glitch_frame idx%0d: got %h expected %h", i, obs_sum, exp_sum);
            end
        end
        n_checks++;
        if (err_total != 0 || obs_sum.times !== 16'h4321 || obs_sum.ok !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_effect: got err=%0d times=%h ok=%b expected err=0 times=4321 ok=1", err_total, obs_sum.times, obs_sum.ok);
        end
    endtask

    task automatic test_out_of_order();
        int         seq_i [7] = '{0, 1, 3, 0, 1, 2, 3};
        logic [3:0] seq_d [7] = '{4'h1, 4'h2, 4'h9, 4'h5, 4'h6, 4'h7, 4'h8};
        for (int k = 0; k < 7; k++) begin
            run_slot(idx_to_sel(seq_i[k]), seq_d[k], 10);
            $display("order slot%0d idx%0d: obs %h", k, seq_i[k], obs_sum);
            n_checks++;
            if (obs_sum !== exp_sum) begin
                n_fail++;
                $display("FAIL out_of_order slot%0d: got %h expected %h", k, obs_sum, exp_sum);
            end
            if (k == 2) begin
                n_checks++;
                if (obs_sum.err_cnt !== 8'd1 || obs_sum.ok !== 1'b0 || obs_sum.times[15:12] !== 4'h9) begin
                    n_fail++;
                    $display("FAIL ooo_drop: got err=%0d ok=%b time3=%h expected err=1 ok=0 time3=9", obs_sum.err_cnt, obs_sum.ok, obs_sum.times[15:12]);
                end
            end
            if (k == 3 || k == 6) begin
                n_checks++;
                if (obs_sum.fd_cnt !== ((k == 6) ? 8'd1 : 8'd0)) begin
                    n_fail++;
                    $display("FAIL ooo_resync slot%0d: got fd=%0d expected %0d", k, obs_sum.fd_cnt, (k == 6) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [15:0] times_before;
        times_before = {time3, time2, time1, time0};
        run_slot(4'b0011, 4'hA, 8);
        $display("illegal slot: obs %h", obs_sum);
        n_checks++;
        if (obs_sum !== exp_sum) begin
            n_fail++;
            $display("FAIL illegal_slot: got %h expected %h", obs_sum, exp_sum);
        end
        n_checks++;
        if (obs_sum.err_cnt !== 8'd1 || obs_sum.times !== times_before || obs_sum.ok !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_effect: got err=%0d times=%h ok=%b expected err=1 times=%h ok=1", obs_sum.err_cnt, obs_sum.times, obs_sum.ok, times_before);
        end
        for (int i = 0; i < 4; i++) begin
            run_slot(idx_to_sel(i), 4'(i + 6), 10);
            n_checks++;
            if (obs_sum !== exp_sum) begin
                n_fail++;
                $display("FAIL illegal_after idx%0d: got %h expected %h", i, obs_sum, exp_sum);
            end
        end
        n_checks++;
        if (obs_sum.fd_cnt !== 8'd1 || obs_sum.err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL illegal_state_kept: got fd=%0d err=%0d expected fd=1 err=0", obs_sum.fd_cnt, obs_sum.err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++) begin
            int idx;
            idx = (k == 0) ? 0 : k - 1;
            run_slot(idx_to_sel(idx), 4'hC - 4'(idx), 10);
            $display("back_to_back slot%0d idx%0d: obs %h", k, idx, obs_sum);
            n_checks++;
            if (obs_sum !== exp_sum) begin
                n_fail++;
                $display("FAIL back_to_back slot%0d: got %h expected %h", k, obs_sum, exp_sum);
            end
            if (k == 1) begin
                n_checks++;
                if (obs_sum.err_cnt !== 8'd0) begin
                    n_fail++;
                    $display("FAIL back_to_back_reaccept: got err=%0d expected 0", obs_sum.err_cnt);
                end
            end
        end
    endtask

    task automatic test_timeout();
        run_slot(4'hF, 4'h0, 1100);
        $display("timeout slot: obs %h", obs_sum);
        n_checks++;
        if (obs_sum !== exp_sum) begin
            n_fail++;
            $display("FAIL timeout_slot: got %h expected %h", obs_sum, exp_sum);
        end
        n_checks++;
        if (obs_sum.err_cnt !== 8'd1 || obs_sum.ok !== 1'b0 || obs_sum.err_edge !== 16'(TIMEOUT - (10 - ACC_EDGE))) begin
            n_fail++;
            $display("FAIL timeout_err: got err=%0d edge=%0d ok=%b expected err=1 edge=%0d ok=0", obs_sum.err_cnt, obs_sum.err_edge, obs_sum.ok, TIMEOUT - (10 - ACC_EDGE));
        end
        for (int i = 0; i < 4; i++) begin
            run_slot(idx_to_sel(i), 4'(i + 1), 10);
            n_checks++;
            if (obs_sum !== exp_sum) begin
                n_fail++;
                $display("FAIL timeout_relock idx%0d: got %h expected %h", i, obs_sum, exp_sum);
            end
        end
        n_checks++;
        if (obs_sum.fd_cnt !== 8'd1 || obs_sum.ok !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_relocked: got fd=%0d ok=%b expected fd=1 ok=1", obs_sum.fd_cnt, obs_sum.ok);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            run_slot(idx_to_sel(i), 4'(i + 3), 10);
            n_checks++;
            if (obs_sum !== exp_sum) begin
                n_fail++;
                $display("FAIL reset_mid_pre idx%0d: got %h expected %h", i, obs_sum, exp_sum);
            end
        end
        rst_n = 1'b0;
        dig_4 = 4'h0;
        bus_4 = 4'hF;
        #1;
        $display("reset_mid asserted: times=%h fd=%b ok=%b err=%b", {time3, time2, time1, time0}, frame_done, scan_ok, err);
        n_checks++;
        if ({time3, time2, time1, time0} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid_times: got %h expected 0000", {time3, time2, time1, time0});
        end
        n_checks++;
        if ({frame_done, scan_ok, err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_flags: got fd/ok/err=%b expected 000", {frame_done, scan_ok, err});
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_last_legal = edge_ctr;
        for (int i = 2; i < 4; i++) begin
            run_slot(idx_to_sel(i), 4'(i + 3), 10);
            n_checks++;
            if (obs_sum !== exp_sum || obs_sum.fd_cnt !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_mid_post idx%0d: got %h expected %h", i, obs_sum, exp_sum);
            end
        end
        for (int i = 0; i < 4; i++) begin
            run_slot(idx_to_sel(i), 4'(i + 1), 10);
            n_checks++;
            if (obs_sum !== exp_sum) begin
                n_fail++;
                $display("FAIL reset_mid_relock idx%0d: got %h expected %h", i, obs_sum, exp_sum);
            end
        end
    endtask

    task automatic test_random();
        int pos = 0;
        for (int k = 0; k < 200; k++) begin
            int r, len;
            logic [3:0] sel, dig;
            r   = $urandom_range(0, 99);
            dig = 4'($urandom_range(0, 15));
            len = $urandom_range(STABLE + 3, 14);
            if (r < 8) begin
                sel = 4'($urandom_range(0, 15));
                len = $urandom_range(1, STABLE - 1);
            end else if (r < 14) begin
                sel = 4'($urandom_range(0, 15));
            end else if (r < 20) begin
                sel = idx_to_sel($urandom_range(0, 3));
            end else begin
                sel = idx_to_sel(pos);
                pos = (pos + 1) % 4;
            end
            if ({dig, sel} == m_prev_val) dig = dig + 4'd1;
            run_slot(sel, dig, len);
            $display("random slot%0d sel=%b dig=%h len=%0d: obs %h", k, sel, dig, len, obs_sum);
            n_checks++;
            if (obs_sum !== exp_sum) begin
                n_fail++;
                $display("FAIL random slot%0d: got %h expected %h", k, obs_sum, exp_sum);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_frames();
        test_glitch();
        test_out_of_order();
        test_illegal();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Receive-side counterpart of the four-digit time-multiplexed display scanner: observes the scanned digit bus (`dig_4`) and active-low digit select (`bus_4`) and rebuilds the four 4-bit digit values. It runs on the fast system clock, asynchronous to the scan clock, so it synchronizes and debounces the bus. It checks the scan order (digit 0→1→2→3→0) and reports frame completion, lock status and protocol errors. It is used for display readback, self-test and bench checking of the scanner.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive identical synchronized samples required before a bus value is accepted. Legal range is 2..255.
- `TIMEOUT_CYCLES`, default 1024: number of clk cycles without an accepted legal digit before lock is dropped. Must be ≥ 4·(STABLE_CYCLES+3).
- `clk` input 1: system clock. It must give each scan slot ≥ STABLE_CYCLES+3 cycles.
- `rst_n` input 1: asynchronous, active-low reset.
- `dig_4` input 4: scanned digit value. Asynchronous to `clk`.
- `bus_4` input 4: active-low digit select. Asynchronous to `clk`.
- `time0`..`time3` output 4 each: reconstructed digits. `time0` is the digit selected by `bus_4`=0111; `time3` is the digit selected by 1110.
- `frame_done` output 1: one-cycle pulse when a complete, in-order 0-1-2-3 frame finishes.
- `scan_ok` output 1: level, high while locked to a correctly ordered scan.
- `err` output 1: one-cycle pulse on an illegal select, an out-of-order digit, or a timeout.

## Operation
- Synchronizer: `{dig_4,bus_4}` passes through two flops. Reset value is dig 0, sel 1111.
- Stability filter:
  - `stab_cnt` clears whenever the stage-2 sample differs from the held sample; otherwise it increments.
  - The sample is accepted exactly once per stable period, when `stab_cnt` reaches STABLE_CYCLES-1. After that the counter saturates with no re-accept.
- Select decode on accept:
  - 0111→idx0, 1011→idx1, 1101→idx2, 1110→idx3.
  - 1111 is blanking: no update, no error.
  - Any other pattern is illegal: `err` pulses and nothing else changes.
- On a legal accept, `time[idx]` is loaded with the accepted dig and the timeout counter clears. This applies in every FSM state.
- FSM, with an `expected` index of 2 bits:
  - IDLE (reset state): accepting idx0 → SYNCING, expected=1. Other indices are ignored with no error.
  - SYNCING: idx==expected → expected+1. If idx3 is accepted in order, pulse `frame_done` and go to LOCKED, expected=0.
  - LOCKED: idx==expected → expected+1 mod 4. Each in-order idx3 pulses `frame_done`.
  - Out-of-order idx in SYNCING or LOCKED:
    - `err` pulses.
    - If idx==0, go to SYNCING with expected=1.
    - Otherwise go to IDLE.
- `scan_ok` = (state==LOCKED).
- Timeout:
  - The counter increments every cycle and saturates at TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES in SYNCING or LOCKED: go to IDLE and pulse `err` once.
  - In IDLE, a timeout produces no error.
- Simultaneous error sources in one cycle produce a single `err` pulse.
- Reset mid-operation: all state returns to reset values immediately. No partial frame survives.

## Timing
- Reset values: `time0`..`time3`=0, `frame_done`=0, `scan_ok`=0, `err`=0, FSM=IDLE, expected=0, counters=0.
- All outputs are registered.
- Latency: an input change first sampled at clk edge N causes its `time[idx]`/`frame_done`/`err` update at edge N+STABLE_CYCLES+1.
- `scan_ok` rises on the same edge as the first `frame_done` after IDLE. It falls on the same edge as the `err` that causes the drop.
- A glitch shorter than STABLE_CYCLES samples is never accepted and never flags an error.
- Back-to-back identical values separated only by an unchanged sample are one stable period, so they are accepted once.

## Test plan
- Reset then scan (STABLE_CYCLES=4, 10 clk per slot) with time0..3=1,2,3,4 for 3 frames:
  - `time0..3`=1,2,3,4.
  - `frame_done` pulses 3 times, one cycle each, 5 edges after each idx3 slot begins sampling.
  - `scan_ok` rises with the first pulse. `err` never asserts.
- While LOCKED, inject a 2-cycle glitch of `bus_4`=1011, `dig_4`=F in the idx0 slot: no output change and no `err`.
- While LOCKED, present slot order 0,1,3:
  - `err` pulses once and `scan_ok` drops.
  - `time3` is still loaded.
  - The next idx0 gives no `frame_done` until the following idx3.
- Hold `bus_4`=0011 for 8 cycles: one `err` pulse, digits unchanged, FSM state unchanged.
- While LOCKED, hold `bus_4`=1111 for 1100 cycles: exactly one `err` at the timeout and `scan_ok`=0. After that, a normal scan relocks within one frame.
- Assert `rst_n`=0 mid-frame (after idx1): all outputs go to 0 asynchronously. After release, the remaining idx2/idx3 slots give no `frame_done`.
